stopwatch_ctrl: RTL and testbench

//   Control sequencer for the 4-digit BCD stopwatch datapath (M:SS.T counter plus 7-seg mux).

---
 rtl/stopwatch_ctrl.sv | 150 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: debounces the start/stop and lap/reset buttons, runs the
// idle/running/paused/lap state machine and selects live or frozen digits for the display.
module stopwatch_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DB_W            = 19
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_btn_ss,
  input  logic        i_btn_lr,
  input  logic [15:0] i_count_bcd,
  output logic        o_run,
  output logic        o_clr,
  output logic [15:0] o_disp_bcd,
  output logic        o_lap_active,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StRunning = 2'b01,
    StPaused  = 2'b10,
    StLap     = 2'b11
  } state_e;

  localparam logic [DB_W-1:0] DbLast = DB_W'(DEBOUNCE_CYCLES - 1);

  // Bit 0 is the start/stop button, bit 1 the lap/reset button.
  logic [1:0]      w_btn_raw;
  logic [1:0]      r_sync1;
  logic [1:0]      r_sync2;
  logic [1:0]      r_db;
  logic [1:0]      r_db_q;
  logic [1:0]      r_press;
  logic [DB_W-1:0] r_db_cnt [2];

  state_e          r_state;
  state_e          w_state_d;
  logic [15:0]     r_lap;
  logic [15:0]     w_lap_d;
  logic            r_clr;
  logic            w_clr_d;
  logic            w_ss;
  logic            w_lr;

  assign w_btn_raw = {i_btn_lr, i_btn_ss};

  // Two-flop synchronisers for the asynchronous buttons.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce each synchronised level and register a one-cycle pulse on accepted presses.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_db     <= '0;
      r_db_q   <= '0;
      r_press  <= '0;
      for (int i = 0; i < 2; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_db_q  <= r_db;
      r_press <= r_db & ~r_db_q;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DbLast) begin
          r_db[i]     <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Start/stop has priority: a coincident lap/reset press is dropped entirely.
  assign w_ss = r_press[0];
  assign w_lr = r_press[1] & ~r_press[0];

  // Next-state, lap capture and clear request.
  always_comb begin
    w_state_d = r_state;
    w_lap_d   = r_lap;
    w_clr_d   = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_ss) begin
          w_state_d = StRunning;
        end else if (w_lr) begin
          w_clr_d = 1'b1;
        end
      end
      StRunning: begin
        if (w_ss) begin
          w_state_d = StPaused;
        end else if (w_lr) begin
          w_state_d = StLap;
          w_lap_d   = i_count_bcd;
        end
      end
      StLap: begin
        if (w_ss) begin
          w_state_d = StPaused;
        end else if (w_lr) begin
          w_state_d = StRunning;
        end
      end
      StPaused: begin
        if (w_ss) begin
          w_state_d = StRunning;
        end else if (w_lr) begin
          w_state_d = StIdle;
          w_clr_d   = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State, lap register and clear pulse.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_lap   <= '0;
      r_clr   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_lap   <= w_lap_d;
      r_clr   <= w_clr_d;
    end
  end

  // Outputs decoded directly from the state register.
  always_comb begin
    o_state      = r_state;
    o_run        = (r_state == StRunning) || (r_state == StLap);
    o_lap_active = (r_state == StLap);
    o_disp_bcd   = (r_state == StLap) ? r_lap : i_count_bcd;
    o_clr        = r_clr;
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with a short debounce window.
module tb_stopwatch_ctrl;

  localparam int unsigned Deb = 4;
  // A button driven just after edge c is first sampled on edge c+1; the new state is visible
  // after edge c+1+Deb+3.
  localparam int Lat = Deb + 4;

  typedef struct {
    string       tag;
    int          cyc;
    logic [1:0]  st;
    logic        run;
    logic        clr;
    logic        lap;
    logic [15:0] disp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_ss;
  logic        btn_lr;
  logic [15:0] count;
  logic        run;
  logic        clr;
  logic [15:0] disp;
  logic        lap;
  logic [1:0]  state;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  stopwatch_ctrl #(
    .DEBOUNCE_CYCLES(Deb),
    .DB_W           (3)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_btn_ss    (btn_ss),
    .i_btn_lr    (btn_lr),
    .i_count_bcd (count),
    .o_run       (run),
    .o_clr       (clr),
    .o_disp_bcd  (disp),
    .o_lap_active(lap),
    .o_state     (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  // Expected outputs 'off' cycles from now; run and lap_active follow from the state.
  task automatic expect_at(input string tag, input int off, input logic [1:0] st,
                           input logic [15:0] d, input logic c);
    exp_t e;
    e.tag  = tag;
    e.cyc  = cyc + off;
    e.st   = st;
    e.run  = (st == 2'b01) || (st == 2'b11);
    e.lap  = (st == 2'b11);
    e.clr  = c;
    e.disp = d;
    sb_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic ss, input logic lr, input int hold);
    btn_ss = ss;
    btn_lr = lr;
    step(hold);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
  endtask

  // Wait for pending expectations, then let button releases settle.
  task automatic drain();
    int t = 0;
    while (sb_q.size() > 0 && t < 200) begin
      step(1);
      t++;
    end
    if (sb_q.size() > 0) begin
      check("drain_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
    step(10);
  endtask

  // Compare queued expectations on the falling edge of their cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        if (e.cyc < cyc) begin
          check({e.tag, ".missed"}, cyc, e.cyc);
        end else begin
          check({e.tag, ".state"}, state, e.st);
          check({e.tag, ".run"},   run,   e.run);
          check({e.tag, ".clr"},   clr,   e.clr);
          check({e.tag, ".lap"},   lap,   e.lap);
          check({e.tag, ".disp"},  disp,  e.disp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    rst    = 1'b1;
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    count  = 16'h0000;
    step(3);
    expect_at("reset", 0, 2'b00, 16'h0000, 1'b0);
    step(2);

    // 1: button raised with reset release, held 12 cycles.
    expect_at("t1.pre",  Lat - 1, 2'b00, 16'h0000, 1'b0);
    expect_at("t1.run",  Lat,     2'b01, 16'h0000, 1'b0);
    expect_at("t1.hold", 13,      2'b01, 16'h0000, 1'b0);
    expect_at("t1.rel",  24,      2'b01, 16'h0000, 1'b0);
    rst = 1'b0;
    press(1'b1, 1'b0, 12);
    drain();

    // 2: glitches rejected, then one clean press.
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    expect_at("t2.g4",  4,  2'b00, 16'h0000, 1'b0);
    expect_at("t2.g8",  8,  2'b00, 16'h0000, 1'b0);
    expect_at("t2.g12", 12, 2'b00, 16'h0000, 1'b0);
    expect_at("t2.g16", 16, 2'b00, 16'h0000, 1'b0);
    press(1'b1, 1'b0, 2);
    step(1);
    press(1'b1, 1'b0, 2);
    drain();
    expect_at("t2.pre",  Lat - 1, 2'b00, 16'h0000, 1'b0);
    expect_at("t2.run",  Lat,     2'b01, 16'h0000, 1'b0);
    expect_at("t2.hold", 16,      2'b01, 16'h0000, 1'b0);
    press(1'b1, 1'b0, 6);
    drain();

    // 3: lap freezes the display while the count moves on.
    count = 16'h0123;
    expect_at("t3.pre",    Lat - 1, 2'b01, 16'h0123, 1'b0);
    expect_at("t3.lap",    Lat,     2'b11, 16'h0123, 1'b0);
    expect_at("t3.frozen", Lat + 2, 2'b11, 16'h0123, 1'b0);
    press(1'b0, 1'b1, 6);
    step(3);
    count = 16'h0124;
    drain();
    expect_at("t3.pre2", Lat - 1, 2'b11, 16'h0123, 1'b0);
    expect_at("t3.back", Lat,     2'b01, 16'h0124, 1'b0);
    expect_at("t3.live", Lat + 2, 2'b01, 16'h0125, 1'b0);
    press(1'b0, 1'b1, 6);
    step(3);
    count = 16'h0125;
    drain();

    // 4: pause, then clear back to idle with a single clr cycle.
    expect_at("t4.pre",   Lat - 1, 2'b01, 16'h0125, 1'b0);
    expect_at("t4.pause", Lat,     2'b10, 16'h0125, 1'b0);
    press(1'b1, 1'b0, 6);
    drain();
    expect_at("t4.pre2", Lat - 1, 2'b10, 16'h0125, 1'b0);
    expect_at("t4.clr",  Lat,     2'b00, 16'h0125, 1'b1);
    expect_at("t4.post", Lat + 1, 2'b00, 16'h0125, 1'b0);
    press(1'b0, 1'b1, 6);
    drain();

    // 5: simultaneous presses from running: start/stop wins.
    expect_at("t5.start", Lat, 2'b01, 16'h0125, 1'b0);
    press(1'b1, 1'b0, 6);
    drain();
    expect_at("t5.pre",  Lat - 1, 2'b01, 16'h0125, 1'b0);
    expect_at("t5.both", Lat,     2'b10, 16'h0125, 1'b0);
    expect_at("t5.c1",   Lat + 1, 2'b10, 16'h0125, 1'b0);
    expect_at("t5.c2",   Lat + 2, 2'b10, 16'h0125, 1'b0);
    expect_at("t5.c8",   Lat + 8, 2'b10, 16'h0125, 1'b0);
    press(1'b1, 1'b1, 12);
    drain();

    // 6: reset while a lap value is frozen.
    count = 16'h0530;
    expect_at("t6.run", Lat, 2'b01, 16'h0530, 1'b0);
    press(1'b1, 1'b0, 6);
    drain();
    expect_at("t6.lap", Lat, 2'b11, 16'h0530, 1'b0);
    press(1'b0, 1'b1, 6);
    drain();
    count = 16'h0531;
    rst   = 1'b1;
    expect_at("t6.before", 0, 2'b11, 16'h0530, 1'b0);
    expect_at("t6.reset",  1, 2'b00, 16'h0531, 1'b0);
    expect_at("t6.after",  2, 2'b00, 16'h0531, 1'b0);
    step(1);
    rst = 1'b0;
    drain();

    // 7: button held through reset gives exactly one press after release.
    btn_ss = 1'b1;
    rst    = 1'b1;
    step(3);
    expect_at("t7.pre",  Lat - 1, 2'b00, 16'h0531, 1'b0);
    expect_at("t7.run",  Lat,     2'b01, 16'h0531, 1'b0);
    expect_at("t7.hold", 20,      2'b01, 16'h0531, 1'b0);
    rst = 1'b0;
    step(12);
    btn_ss = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
